// File: rtl/psum_pass_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : psum_pass_scheduler
// Description : Layer-level sequencer for the PSUM readout path. Latches one
//               conv layer configuration, loads it into psum_callback with a
//               code_valid pulse, then runs one accumulate/readout pass per
//               output channel with a guard gap between passes.
// Ports       : s_clk/s_rst            - clock, synchronous active-high reset
//               layer_start, cfg_*     - start request and layer configuration
//               array_acc_done         - PE array finished current channel
//               Array_out_done         - psum_callback finished readout
//               code_valid, conv_*     - configuration load pulse and registers
//               o_read_data_mode       - readout window (rising edge starts it)
//               array_start            - starts accumulation of one channel
//               o_out_ch_idx           - current output channel index
//               layer_busy/layer_done  - status and completion pulse
//               cfg_err/timeout_err    - rejected start pulse, sticky watchdog
// Revision    : 1.0 - initial release
// ============================================================================
module psum_pass_scheduler #(
  parameter int GAP_MIN     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        s_clk,
  input  logic        s_rst,
  input  logic        layer_start,
  input  logic [15:0] cfg_in_ch,
  input  logic [15:0] cfg_out_ch,
  input  logic [15:0] cfg_img_size,
  input  logic [15:0] cfg_lif_thrd,
  input  logic [15:0] cfg_bias_scale,
  input  logic        cfg_conv_or_maxpool,
  input  logic        array_acc_done,
  input  logic        Array_out_done,
  output logic        code_valid,
  output logic [15:0] conv_in_ch,
  output logic [15:0] conv_out_ch,
  output logic [15:0] conv_img_size,
  output logic [15:0] conv_lif_thrd,
  output logic [15:0] conv_bias_scale,
  output logic        conv_or_maxpool,
  output logic        o_read_data_mode,
  output logic        array_start,
  output logic [15:0] o_out_ch_idx,
  output logic        layer_busy,
  output logic        layer_done,
  output logic        cfg_err,
  output logic        timeout_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CFG  = 3'd1;
  localparam logic [2:0] ST_ACC  = 3'd2;
  localparam logic [2:0] ST_READ = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [16:0] TMO_LIM = 17'(TIMEOUT_CYC);
  localparam bit          TMO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [16:0] GAP_LEN_BASE = 17'(GAP_MIN);

  logic [2:0]  state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] in_ch_q, in_ch_d;
  logic [15:0] out_ch_q, out_ch_d;
  logic [15:0] img_q, img_d;
  logic [15:0] lif_q, lif_d;
  logic [15:0] bias_q, bias_d;
  logic        cmp_q, cmp_d;
  logic        cfg_err_q, cfg_err_d;
  logic        tmo_q, tmo_d;

  logic        cfg_ok;
  logic [16:0] wd_sum;
  logic [15:0] wd_inc;
  logic        wd_hit;
  logic [16:0] gap_len;
  logic [15:0] gap_load;
  logic [16:0] idx_inc;
  logic        more_ch;

  assign cfg_ok = (cfg_img_size >= 16'd4) && (cfg_out_ch != 16'd0) &&
                  (cfg_bias_scale <= 16'd63);

  // Watchdog saturates so it can never wrap back to 0 and fake a first ACC
  // cycle (array_start is keyed off wd_q == 0) when the watchdog is disabled.
  assign wd_sum = {1'b0, wd_q} + 17'd1;
  assign wd_inc = (wd_q == 16'hFFFF) ? wd_q : wd_sum[15:0];
  assign wd_hit = TMO_EN && (wd_sum == TMO_LIM);

  // Gap counter counts down from len-1 so GAP lasts exactly len cycles.
  assign gap_len  = GAP_LEN_BASE + {1'b0, bias_q};
  assign gap_load = (gap_len == 17'd0) ? 16'd0 : 16'(gap_len - 17'd1);

  // 17-bit compare so out_ch = 65535 terminates without index wrap.
  assign idx_inc = {1'b0, idx_q} + 17'd1;
  assign more_ch = idx_inc < {1'b0, out_ch_q};

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    in_ch_d   = in_ch_q;
    out_ch_d  = out_ch_q;
    img_d     = img_q;
    lif_d     = lif_q;
    bias_d    = bias_q;
    cmp_d     = cmp_q;
    cfg_err_d = 1'b0;
    tmo_d     = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (layer_start) begin
          if (cfg_ok) begin
            in_ch_d  = cfg_in_ch;
            out_ch_d = cfg_out_ch;
            img_d    = cfg_img_size;
            lif_d    = cfg_lif_thrd;
            bias_d   = cfg_bias_scale;
            cmp_d    = cfg_conv_or_maxpool;
            idx_d    = 16'd0;
            tmo_d    = 1'b0;
            state_d  = ST_CFG;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_CFG: begin
        wd_d    = 16'd0;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        // Done pulse has priority over a same-cycle watchdog expiry.
        if (array_acc_done) begin
          wd_d    = 16'd0;
          state_d = ST_READ;
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_READ: begin
        if (Array_out_done) begin
          gap_d   = gap_load;
          state_d = ST_GAP;
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_GAP: begin
        if (gap_q == 16'd0) begin
          idx_d = idx_inc[15:0];
          if (more_ch) begin
            wd_d    = 16'd0;
            state_d = ST_ACC;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      wd_q      <= 16'd0;
      gap_q     <= 16'd0;
      idx_q     <= 16'd0;
      in_ch_q   <= 16'd0;
      out_ch_q  <= 16'd0;
      img_q     <= 16'd0;
      lif_q     <= 16'd0;
      bias_q    <= 16'd0;
      cmp_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      in_ch_q   <= in_ch_d;
      out_ch_q  <= out_ch_d;
      img_q     <= img_d;
      lif_q     <= lif_d;
      bias_q    <= bias_d;
      cmp_q     <= cmp_d;
      cfg_err_q <= cfg_err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign code_valid       = (state_q == ST_CFG);
  assign array_start      = (state_q == ST_ACC) && (wd_q == 16'd0);
  assign o_read_data_mode = (state_q == ST_READ);
  assign layer_busy       = (state_q != ST_IDLE);
  assign layer_done       = (state_q == ST_DONE);
  assign cfg_err          = cfg_err_q;
  assign timeout_err      = tmo_q;
  assign o_out_ch_idx     = idx_q;
  assign conv_in_ch       = in_ch_q;
  assign conv_out_ch      = out_ch_q;
  assign conv_img_size    = img_q;
  assign conv_lif_thrd    = lif_q;
  assign conv_bias_scale  = bias_q;
  assign conv_or_maxpool  = cmp_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_pass_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_pass_scheduler
// Description : Self-checking bench for psum_pass_scheduler. A table of layer
//               configurations drives accepted and rejected starts; a negedge
//               monitor pops expected channel indices from a scoreboard and
//               measures gap lengths. Hand-written sequences cover watchdog
//               expiry and reset in the middle of a pass.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_pass_scheduler;

  localparam int TB_GAP_MIN = 4;
  localparam int TB_TMO     = 50;

  logic        s_clk = 1'b0;
  logic        s_rst = 1'b1;
  logic        layer_start = 1'b0;
  logic [15:0] cfg_in_ch = '0, cfg_out_ch = '0, cfg_img_size = '0;
  logic [15:0] cfg_lif_thrd = '0, cfg_bias_scale = '0;
  logic        cfg_conv_or_maxpool = 1'b0;
  logic        array_acc_done = 1'b0;
  logic        Array_out_done = 1'b0;
  logic        code_valid;
  logic [15:0] conv_in_ch, conv_out_ch, conv_img_size, conv_lif_thrd, conv_bias_scale;
  logic        conv_or_maxpool, o_read_data_mode, array_start;
  logic [15:0] o_out_ch_idx;
  logic        layer_busy, layer_done, cfg_err, timeout_err;

  psum_pass_scheduler #(.GAP_MIN(TB_GAP_MIN), .TIMEOUT_CYC(TB_TMO)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .layer_start(layer_start),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .cfg_img_size(cfg_img_size),
    .cfg_lif_thrd(cfg_lif_thrd), .cfg_bias_scale(cfg_bias_scale),
    .cfg_conv_or_maxpool(cfg_conv_or_maxpool),
    .array_acc_done(array_acc_done), .Array_out_done(Array_out_done),
    .code_valid(code_valid), .conv_in_ch(conv_in_ch), .conv_out_ch(conv_out_ch),
    .conv_img_size(conv_img_size), .conv_lif_thrd(conv_lif_thrd),
    .conv_bias_scale(conv_bias_scale), .conv_or_maxpool(conv_or_maxpool),
    .o_read_data_mode(o_read_data_mode), .array_start(array_start),
    .o_out_ch_idx(o_out_ch_idx), .layer_busy(layer_busy), .layer_done(layer_done),
    .cfg_err(cfg_err), .timeout_err(timeout_err)
  );

  always #5 s_clk = ~s_clk;

  int n_cmp = 0;
  int n_err = 0;
  int rise_cnt = 0;
  int exp_gap = 0;
  int gap_cnt = 0;
  bit gap_on = 1'b0;
  bit mode_prev = 1'b0;
  int q_exp[$];
  int q_done[$];
  logic [15:0] last_img = '0, last_oc = '0, last_bias = '0;

  typedef struct {
    logic [15:0] img;
    logic [15:0] oc;
    logic [15:0] bias;
    bit          exp_err;
    bit          inj;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs1"}, {code_valid, o_read_data_mode, array_start, layer_busy,
                            layer_done, cfg_err, timeout_err, conv_or_maxpool}, 0);
    check({tag, "_conv"}, {conv_in_ch | conv_out_ch | conv_img_size |
                           conv_lif_thrd | conv_bias_scale}, 0);
    check({tag, "_idx"}, o_out_ch_idx, 0);
  endtask

  // Scoreboard monitor: checks channel index on each array_start and at
  // layer_done, counts mode rises and measures each guard gap.
  always @(negedge s_clk) begin
    if (o_read_data_mode && !mode_prev) rise_cnt++;
    if (array_start) begin
      check("sb_start_expected", q_exp.size() != 0, 1);
      if (q_exp.size() != 0) check("sb_start_idx", o_out_ch_idx, q_exp.pop_front());
    end
    if (layer_done) begin
      check("sb_done_expected", q_done.size() != 0, 1);
      if (q_done.size() != 0) check("sb_done_idx", o_out_ch_idx, q_done.pop_front());
    end
    if (gap_on && (array_start || layer_done)) begin
      check("gap_len", gap_cnt, exp_gap);
      gap_on = 1'b0;
    end else if (gap_on) begin
      gap_cnt++;
    end
    if (mode_prev && !o_read_data_mode) begin
      gap_on  = 1'b1;
      gap_cnt = 1;
    end
    if (!layer_busy) gap_on = 1'b0;
    mode_prev = o_read_data_mode;
  end

  task automatic set_cfg(input logic [15:0] img, oc, bias);
    cfg_img_size        = img;
    cfg_out_ch          = oc;
    cfg_bias_scale      = bias;
    cfg_in_ch           = img ^ 16'h00F0;
    cfg_lif_thrd        = oc + 16'h0100;
    cfg_conv_or_maxpool = bias[0];
  endtask

  // Full accepted layer: acc_done 10 cycles after each array_start,
  // Array_out_done 20 cycles after each mode rise.
  task automatic run_layer(input logic [15:0] img, oc, bias, input bit inj);
    int  rises0;
    bit  seen;
    int  w;
    bit  do_inj;
    rises0  = rise_cnt;
    exp_gap = TB_GAP_MIN + int'(bias);
    set_cfg(img, oc, bias);
    layer_start = 1'b1;
    q_exp.push_back(0);
    tick();
    layer_start = 1'b0;
    check("code_valid_T1", code_valid, 1);
    check("busy_T1", layer_busy, 1);
    check("cfg_err_valid", cfg_err, 0);
    check("timeout_clr", timeout_err, 0);
    check("idx_clear", o_out_ch_idx, 0);
    check("conv_img", conv_img_size, img);
    check("conv_out", conv_out_ch, oc);
    check("conv_bias", conv_bias_scale, bias);
    check("conv_in", conv_in_ch, img ^ 16'h00F0);
    check("conv_lif", conv_lif_thrd, oc + 16'h0100);
    check("conv_cmp", conv_or_maxpool, bias[0]);
    last_img  = img;
    last_oc   = oc;
    last_bias = bias;
    for (int ch = 0; ch < int'(oc); ch++) begin
      seen = 1'b0;
      w = 0;
      while (w < 200 && !seen) begin
        tick();
        if (ch == 0 && w == 0) check("code_valid_T2", code_valid, 0);
        seen = array_start;
        if (!seen) w++;
      end
      check("array_start_seen", seen, 1);
      if (!seen) return;
      if (ch == 0) check("array_start_T2", w, 0);
      do_inj = inj && (ch == 1);
      for (int c = 0; c < 32; c++) begin
        array_acc_done = (c == 10) || (do_inj && c == 20);
        Array_out_done = (c == 31) || (do_inj && c == 3);
        layer_start    = do_inj && (c == 20);
        if (do_inj && c == 20) cfg_img_size = 16'h0055;
        if (c == 31) begin
          if (ch + 1 < int'(oc)) q_exp.push_back(ch + 1);
          else q_done.push_back(int'(oc));
        end
        tick();
        array_acc_done = 1'b0;
        Array_out_done = 1'b0;
        layer_start    = 1'b0;
        if (c == 0)  check("array_start_pulse", array_start, 0);
        if (c == 9)  check("mode_before_acc", o_read_data_mode, 0);
        if (c == 10) check("mode_rise_A1", o_read_data_mode, 1);
        if (do_inj && c == 3) check("stray_outdone_ign", o_read_data_mode, 0);
        if (do_inj && c == 20) begin
          check("inj_mode_held", o_read_data_mode, 1);
          check("inj_no_cfg", code_valid, 0);
          check("inj_conv_img", conv_img_size, img);
          check("inj_no_start", array_start, 0);
        end
        if (c == 30) check("mode_held", o_read_data_mode, 1);
        if (c == 31) check("mode_fall_D1", o_read_data_mode, 0);
      end
    end
    seen = 1'b0;
    w = 0;
    while (w < 200 && !seen) begin
      tick();
      seen = layer_done;
      w++;
    end
    check("layer_done_seen", seen, 1);
    check("mode_rises", rise_cnt - rises0, int'(oc));
    tick();
    check("busy_fall", layer_busy, 0);
    check("done_pulse", layer_done, 0);
  endtask

  task automatic run_reject(input logic [15:0] img, oc, bias);
    set_cfg(img, oc, bias);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    check("rej_cfg_err", cfg_err, 1);
    check("rej_busy", layer_busy, 0);
    check("rej_code_valid", code_valid, 0);
    check("rej_conv_img", conv_img_size, last_img);
    check("rej_conv_out", conv_out_ch, last_oc);
    check("rej_conv_bias", conv_bias_scale, last_bias);
    tick();
    check("rej_cfg_err_pulse", cfg_err, 0);
    check("rej_busy2", layer_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    tbl[0] = '{img: 16'd8,     oc: 16'd3, bias: 16'd2,  exp_err: 1'b0, inj: 1'b0};
    tbl[1] = '{img: 16'd4,     oc: 16'd1, bias: 16'd63, exp_err: 1'b0, inj: 1'b0};
    tbl[2] = '{img: 16'd65535, oc: 16'd2, bias: 16'd0,  exp_err: 1'b0, inj: 1'b1};
    tbl[3] = '{img: 16'd3,     oc: 16'd2, bias: 16'd0,  exp_err: 1'b1, inj: 1'b0};
    tbl[4] = '{img: 16'd8,     oc: 16'd0, bias: 16'd2,  exp_err: 1'b1, inj: 1'b0};
    tbl[5] = '{img: 16'd8,     oc: 16'd1, bias: 16'd64, exp_err: 1'b1, inj: 1'b0};

    s_rst = 1'b1;
    tick();
    tick();
    s_rst = 1'b0;
    check_all_zero("reset");

    // Valid rows run back-to-back: each start lands the cycle after layer_done.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].exp_err) run_reject(tbl[i].img, tbl[i].oc, tbl[i].bias);
      else run_layer(tbl[i].img, tbl[i].oc, tbl[i].bias, tbl[i].inj);
    end

    // Watchdog: Array_out_done never arrives.
    set_cfg(16'd8, 16'd2, 16'd1);
    layer_start = 1'b1;
    q_exp.push_back(0);
    tick();
    layer_start = 1'b0;
    tick();
    check("wd_array_start", array_start, 1);
    repeat (10) tick();
    array_acc_done = 1'b1;
    tick();
    array_acc_done = 1'b0;
    check("wd_read_entry", o_read_data_mode, 1);
    repeat (49) tick();
    check("wd_err_R49", timeout_err, 0);
    check("wd_mode_R49", o_read_data_mode, 1);
    tick();
    check("wd_err_R50", timeout_err, 1);
    check("wd_mode_drop", o_read_data_mode, 0);
    check("wd_busy", layer_busy, 0);
    repeat (5) tick();
    check("wd_sticky", timeout_err, 1);
    check("wd_no_done", q_done.size(), 0);

    // Accepted start clears the sticky flag (checked inside run_layer).
    run_layer(16'd12, 16'd1, 16'd0, 1'b0);

    // Reset while in GAP.
    set_cfg(16'd8, 16'd2, 16'd5);
    layer_start = 1'b1;
    q_exp.push_back(0);
    tick();
    layer_start = 1'b0;
    tick();
    repeat (10) tick();
    array_acc_done = 1'b1;
    tick();
    array_acc_done = 1'b0;
    repeat (3) tick();
    Array_out_done = 1'b1;
    q_exp.push_back(1);
    tick();
    Array_out_done = 1'b0;
    tick();
    check("rst_in_gap_mode", o_read_data_mode, 0);
    check("rst_in_gap_busy", layer_busy, 1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    q_exp.delete();
    q_done.delete();
    check_all_zero("mid_rst");
    last_img  = '0;
    last_oc   = '0;
    last_bias = '0;
    repeat (8) tick();
    check_all_zero("post_rst");
    run_layer(16'd8, 16'd1, 16'd0, 1'b0);

    check("sb_queue_empty", q_exp.size() + q_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psum_pass_scheduler.md
# psum_pass_scheduler

Layer-level sequencer for the PSUM readout path. It latches one conv layer's configuration, loads it into `psum_callback` with a `code_valid` pulse, and then runs one pass per output channel. Each pass starts PE-array accumulation, waits for the array to finish, drives the `i_read_data_mode` rising edge that starts PSUM readout and LIF, waits for `Array_out_done`, and inserts a guard gap. The block sits between the layer instruction decoder and the `psum_callback`/PE-array pair.

## Interface
Parameters:
- `GAP_MIN`, default 4: minimum low cycles of `o_read_data_mode` between passes.
- `TIMEOUT_CYC`, default 65535: watchdog limit per wait state; 0 disables the watchdog.

Ports (clock and reset first):
- `s_clk` in 1: the single clock.
- `s_rst` in 1: reset, synchronous, active-high.
- `layer_start` in 1: one-cycle start request; sampled only in IDLE.
- `cfg_in_ch`, `cfg_out_ch`, `cfg_img_size`, `cfg_lif_thrd`, `cfg_bias_scale` in 16 each: layer configuration; sampled with `layer_start`.
- `cfg_conv_or_maxpool` in 1: layer type; sampled with `layer_start`.
- `array_acc_done` in 1: pulse from the PE array meaning the current output channel is fully accumulated in PSUM RAM.
- `Array_out_done` in 1: pulse from `psum_callback` meaning readout of the current channel is complete.
- `code_valid` out 1: one-cycle configuration load pulse.
- `conv_in_ch`, `conv_out_ch`, `conv_img_size`, `conv_lif_thrd`, `conv_bias_scale` out 16 each: registered configuration.
- `conv_or_maxpool` out 1: registered layer type.
- `o_read_data_mode` out 1: 1 during readout; its rising edge starts `psum_callback`.
- `array_start` out 1: one-cycle pulse that starts accumulation of one channel.
- `o_out_ch_idx` out 16: index of the current output channel.
- `layer_busy` out 1: high whenever the state is not IDLE.
- `layer_done` out 1: one-cycle pulse when the layer completes.
- `cfg_err` out 1: one-cycle pulse when a start is rejected.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
States: IDLE, CFG, ACC, READ, GAP, DONE.

- **IDLE**
  - On `layer_start`, validate the configuration: `cfg_img_size >= 4`, `cfg_out_ch != 0`, `cfg_bias_scale <= 63`.
  - Invalid: pulse `cfg_err` next cycle and stay in IDLE. No configuration register changes.
  - Valid: latch all `cfg_*` into the `conv_*` registers, clear `o_out_ch_idx` and `timeout_err`, go to CFG.
- **CFG** (1 cycle): assert `code_valid`, go to ACC.
- **ACC**
  - Assert `array_start` on the first cycle only.
  - Wait for `array_acc_done`, then go to READ.
- **READ**
  - Hold `o_read_data_mode` = 1.
  - Wait for `Array_out_done`, then go to GAP.
- **GAP**
  - Hold `o_read_data_mode` = 0 for exactly `GAP_MIN + conv_bias_scale` cycles, so the callback's bias shift completes before the next edge.
  - On the last gap cycle, increment `o_out_ch_idx`.
  - Go to ACC if the incremented index is less than `conv_out_ch`, otherwise go to DONE.
- **DONE** (1 cycle): pulse `layer_done`, go to IDLE.

Rules:
- `conv_*` outputs stay stable from CFG until the next accepted start.
- `layer_start` outside IDLE is ignored.
- `array_acc_done` outside ACC is ignored.
- `Array_out_done` outside READ is ignored.
- Watchdog:
  - A 16-bit counter clears on entry to ACC and on entry to READ, and counts in both states.
  - If it reaches `TIMEOUT_CYC` (when nonzero), set `timeout_err`, drop `o_read_data_mode`, and go to IDLE without asserting `layer_done`.
  - `timeout_err` clears on the next accepted start or on reset.
- `o_out_ch_idx` is 16-bit; `cfg_out_ch` = 65535 must not wrap before the compare.

## Timing
- Reset (`s_rst` high at a clock edge):
  - State goes to IDLE.
  - All outputs are 0, including the `conv_*` registers and `timeout_err`.
  - This applies mid-pass as well; no pending pulse survives.
- Latencies:
  - `layer_start` at cycle T gives `code_valid` at T+1 and `array_start` at T+2.
  - `array_acc_done` at cycle A gives `o_read_data_mode` = 1 from A+1.
  - `Array_out_done` at cycle D gives `o_read_data_mode` = 0 from D+1.
  - Next `array_start` comes at D+1+`GAP_MIN`+`conv_bias_scale`.
  - On the last channel, `layer_done` comes at D+1+gap and `layer_busy` falls one cycle later.
- Simultaneous events:
  - `array_acc_done` on the first ACC cycle, the same cycle as `array_start`, is accepted.
  - `Array_out_done` on the first READ cycle is accepted.
  - A watchdog expiry in the same cycle as the awaited done pulse: the done pulse wins.

## Test plan
- **Single layer, normal flow.** Configuration img=8, out_ch=3, bias_scale=2. Respond to `array_acc_done` 10 cycles after each `array_start`, and to `Array_out_done` 20 cycles after each mode rise. Required: 1 `code_valid`, 3 `array_start`, 3 rising edges of `o_read_data_mode`, each gap exactly 6 cycles, `o_out_ch_idx` stepping 0→1→2, then `layer_done` once.
- **Rejected start.** `layer_start` with img=3. Required: `cfg_err` pulse at T+1, `layer_busy` stays 0, `conv_*` unchanged.
- **Busy and spurious inputs.** During READ, inject `layer_start`, `array_acc_done`, and a stray `Array_out_done` while in ACC. Required: all ignored, pass count unchanged.
- **Watchdog.** `TIMEOUT_CYC`=50, `Array_out_done` never arrives. Required: `timeout_err` rises 50 cycles after READ entry, `o_read_data_mode` drops, no `layer_done`.
- **Reset mid-pass.** Assert `s_rst` in GAP for 1 cycle. Required: all outputs 0 the next cycle; a new start then produces `code_valid` at T+1.
- **Back-to-back layers.** Issue `layer_start` in the cycle after `layer_done`. Required: accepted, new `conv_*` latched, `o_out_ch_idx` restarts at 0.
